// File: rtl/spi_reg_controller.sv
// -----------------------------------------------------------------------------
// spi_reg_controller
// Frame-level controller on the ext_clk side of spi_slave. It turns the
// received byte stream into register-bus reads and writes, and it stages the
// reply bytes that spi_slave shifts out on MISO.
//
// Frame: byte0 = {rw, addr[6:0]} (rw = 1 read), then data bytes. The address
// auto-increments after each data byte when AUTO_INC = 1. Read frames spend
// byte1 as a turnaround byte (reply = STATUS) while the first register is
// fetched.
//
// Ports
//   ext_clk       system clock (~16x sclk)
//   rst_n         asynchronous active-low reset
//   spi_ss        raw slave select, active-low; synchronised here
//   recv_data     received byte from spi_slave
//   recv_ready    one-cycle pulse per received byte
//   send_ready    spi_slave may take a new send_data while high
//   send_data     reply byte; changes only while send_ready is high
//   reg_addr      register address
//   reg_wdata     write data
//   reg_we        one-cycle write strobe
//   reg_re        one-cycle read strobe
//   reg_rdata     read data, valid exactly one cycle after reg_re
//   frame_active  high from the command byte until synchronised ss rises
//   frame_err     sticky out-of-range flag for the current/last frame
// -----------------------------------------------------------------------------
module spi_reg_controller #(
   parameter int unsigned REG_COUNT = 128,
   parameter logic [3:0]  STATUS_ID = 4'hA,
   parameter bit          AUTO_INC  = 1'b1
) (
   input  logic       ext_clk,
   input  logic       rst_n,
   input  logic       spi_ss,
   input  logic [7:0] recv_data,
   input  logic       recv_ready,
   input  logic       send_ready,
   output logic [7:0] send_data,
   output logic [6:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       frame_active,
   output logic       frame_err
);

   typedef enum logic [1:0] {IDLE, WR, RD_TURN, RD} state_e;

   localparam logic [7:0] REG_LIMIT    = 8'(REG_COUNT);
   localparam logic [7:0] STATUS_RESET = {STATUS_ID, 4'b0001};

   state_e     state_q, state_d;
   logic       ss_meta_q, ss_meta_d, ss_s_q, ss_s_d;
   logic [1:0] settle_q, settle_d;
   logic       armed_q, armed_d;
   logic [6:0] addr_q, addr_d;
   logic [6:0] reg_addr_q, reg_addr_d;
   logic [7:0] reg_wdata_q, reg_wdata_d;
   logic       reg_we_q, reg_we_d, reg_re_q, reg_re_d;
   logic       rd_skip_q, rd_skip_d;
   logic       cap_q, cap_d, cap_zero_q, cap_zero_d;
   logic [7:0] stage_q, stage_d, hold_q, hold_d;
   logic       frame_active_q, frame_active_d;
   logic       frame_err_q, frame_err_d;
   logic [7:0] status;
   logic [6:0] nxt_addr;

   function automatic logic in_range(input logic [6:0] a);
      return {1'b0, a} < REG_LIMIT;
   endfunction

   function automatic logic [6:0] step_addr(input logic [6:0] a);
      return AUTO_INC ? a + 7'd1 : a;
   endfunction

   assign status   = {STATUS_ID, 2'b00, frame_err_q, 1'b1};
   assign nxt_addr = step_addr(addr_q);

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      // Two-flop synchroniser on the raw slave select.
      ss_meta_d      = spi_ss;
      ss_s_d         = ss_meta_q;
      // A command is accepted only after ss has been seen high on settled
      // synchroniser samples, so a reset mid-frame never decodes a data byte
      // of the interrupted frame as a command.
      settle_d       = {settle_q[0], 1'b1};
      armed_d        = armed_q | (settle_q[1] & ss_s_q);
      state_d        = state_q;
      addr_d         = addr_q;
      reg_addr_d     = reg_addr_q;
      reg_wdata_d    = reg_wdata_q;
      reg_we_d       = 1'b0;
      reg_re_d       = 1'b0;
      rd_skip_d      = 1'b0;
      // Read data arrives one cycle after reg_re; an out-of-range read stages 0.
      cap_d          = reg_re_q | rd_skip_q;
      cap_zero_d     = rd_skip_q;
      stage_d        = stage_q;
      frame_active_d = frame_active_q;
      frame_err_d    = frame_err_q;
      hold_d         = send_ready ? stage_q : hold_q;

      if (cap_q) stage_d = cap_zero_q ? 8'h00 : reg_rdata;

      case (state_q)
         IDLE: begin
            stage_d = status;
            if (recv_ready && armed_q && !ss_s_q) begin
               frame_active_d = 1'b1;
               frame_err_d    = 1'b0;
               addr_d         = recv_data[6:0];
               reg_addr_d     = recv_data[6:0];
               if (recv_data[7]) begin
                  state_d = RD_TURN;
                  if (in_range(recv_data[6:0])) begin
                     reg_re_d = 1'b1;
                  end else begin
                     rd_skip_d   = 1'b1;
                     frame_err_d = 1'b1;
                  end
               end else begin
                  state_d = WR;
               end
            end
         end
         WR: begin
            stage_d = status;
            // A byte landing together with ss rising is still written.
            if (recv_ready) begin
               if (in_range(addr_q)) begin
                  reg_we_d    = 1'b1;
                  reg_wdata_d = recv_data;
                  reg_addr_d  = addr_q;
               end else begin
                  frame_err_d = 1'b1;
               end
               addr_d = nxt_addr;
            end
         end
         RD_TURN, RD: begin
            // The slave has just taken stage for the next transfer: fetch the
            // following register so it is staged well before the next byte.
            if (recv_ready && !ss_s_q) begin
               state_d    = RD;
               addr_d     = nxt_addr;
               reg_addr_d = nxt_addr;
               if (in_range(nxt_addr)) begin
                  reg_re_d = 1'b1;
               end else begin
                  rd_skip_d   = 1'b1;
                  frame_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (ss_s_q) begin
         state_d        = IDLE;
         frame_active_d = 1'b0;
         reg_re_d       = 1'b0;
         rd_skip_d      = 1'b0;
         cap_d          = 1'b0;
         stage_d        = status;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples its _d value from before the edge regardless of statement order.
   always_ff @(posedge ext_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         ss_meta_q      <= 1'b1;
         ss_s_q         <= 1'b1;
         settle_q       <= 2'b00;
         armed_q        <= 1'b0;
         addr_q         <= 7'd0;
         reg_addr_q     <= 7'd0;
         reg_wdata_q    <= 8'h00;
         reg_we_q       <= 1'b0;
         reg_re_q       <= 1'b0;
         rd_skip_q      <= 1'b0;
         cap_q          <= 1'b0;
         cap_zero_q     <= 1'b0;
         stage_q        <= STATUS_RESET;
         hold_q         <= STATUS_RESET;
         frame_active_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         ss_meta_q      <= ss_meta_d;
         ss_s_q         <= ss_s_d;
         settle_q       <= settle_d;
         armed_q        <= armed_d;
         addr_q         <= addr_d;
         reg_addr_q     <= reg_addr_d;
         reg_wdata_q    <= reg_wdata_d;
         reg_we_q       <= reg_we_d;
         reg_re_q       <= reg_re_d;
         rd_skip_q      <= rd_skip_d;
         cap_q          <= cap_d;
         cap_zero_q     <= cap_zero_d;
         stage_q        <= stage_d;
         hold_q         <= hold_d;
         frame_active_q <= frame_active_d;
         frame_err_q    <= frame_err_d;
      end
   end

   assign send_data    = send_ready ? stage_q : hold_q;
   assign reg_addr     = reg_addr_q;
   assign reg_wdata    = reg_wdata_q;
   assign reg_we       = reg_we_q;
   assign reg_re       = reg_re_q;
   assign frame_active = frame_active_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_controller
// Directed bench for spi_reg_controller. Two instances share the SPI-side
// stimulus: dut (REG_COUNT = 128) and dut16 (REG_COUNT = 16). A small
// behavioural spi_slave stand-in drives recv_ready/send_ready and samples
// send_data at each send_ready cycle as the MISO byte of the next transfer.
// -----------------------------------------------------------------------------
module tb_spi_reg_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_ss = 1'b1;
   logic [7:0] recv_data = 8'h00;
   logic       recv_ready = 1'b0;
   logic       send_ready = 1'b0;

   logic [7:0] send_data, reg_wdata, reg_rdata;
   logic [6:0] reg_addr;
   logic       reg_we, reg_re, frame_active, frame_err;
   logic [7:0] send_data16, reg_wdata16, reg_rdata16;
   logic [6:0] reg_addr16;
   logic       reg_we16, reg_re16, frame_active16, frame_err16;

   always #5 clk = ~clk;

   spi_reg_controller dut (
      .ext_clk(clk), .rst_n(rst_n), .spi_ss(spi_ss),
      .recv_data(recv_data), .recv_ready(recv_ready), .send_ready(send_ready),
      .send_data(send_data), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
      .frame_active(frame_active), .frame_err(frame_err)
   );

   spi_reg_controller #(.REG_COUNT(16)) dut16 (
      .ext_clk(clk), .rst_n(rst_n), .spi_ss(spi_ss),
      .recv_data(recv_data), .recv_ready(recv_ready), .send_ready(send_ready),
      .send_data(send_data16), .reg_addr(reg_addr16), .reg_wdata(reg_wdata16),
      .reg_we(reg_we16), .reg_re(reg_re16), .reg_rdata(reg_rdata16),
      .frame_active(frame_active16), .frame_err(frame_err16)
   );

   // Register-file contents seen by reads.
   function automatic logic [7:0] rd_val(input logic [6:0] a);
      case (a)
         7'd3:    return 8'h3C;
         7'd4:    return 8'h4D;
         7'd5:    return 8'h5E;
         7'd127:  return 8'h7F;
         default: return {1'b1, a};
      endcase
   endfunction

   // Bus monitor and read responder; data is only valid the cycle after reg_re.
   logic [6:0] we_addr_log [64];
   logic [7:0] we_data_log [64];
   logic [6:0] re_addr_log [64];
   int we_cnt = 0, re_cnt = 0, we16_cnt = 0, both_cnt = 0;

   always @(posedge clk) begin
      reg_rdata   <= reg_re   ? rd_val(reg_addr)   : 8'hEE;
      reg_rdata16 <= reg_re16 ? rd_val(reg_addr16) : 8'hEE;
      if (reg_we) begin
         we_addr_log[we_cnt & 63] <= reg_addr;
         we_data_log[we_cnt & 63] <= reg_wdata;
         we_cnt <= we_cnt + 1;
      end
      if (reg_re) begin
         re_addr_log[re_cnt & 63] <= reg_addr;
         re_cnt <= re_cnt + 1;
      end
      if (reg_we16) we16_cnt <= we16_cnt + 1;
      if ((reg_we && reg_re) || (reg_we16 && reg_re16)) both_cnt <= both_cnt + 1;
   end

   // send_data must not move while send_ready is low.
   logic [7:0] prev_sd, prev_sd16;
   logic       prev_ok = 1'b0;
   int         stab_viol = 0;
   always @(negedge clk) begin
      if (rst_n && prev_ok && !send_ready &&
          (send_data !== prev_sd || send_data16 !== prev_sd16))
         stab_viol <= stab_viol + 1;
      prev_sd   <= send_data;
      prev_sd16 <= send_data16;
      prev_ok   <= rst_n;
   end

   int checks = 0, failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] tx [8];
   logic [7:0] miso [9];
   logic [7:0] miso16 [9];

   // Drives one frame of n bytes and leaves ss low. miso[k] is the byte the
   // slave would shift out during transfer k.
   task automatic run_frame(input int n);
      spi_ss = 1'b0;
      repeat (4) tick();
      send_ready = 1'b1;
      tick();
      @(negedge clk);
      miso[0]   = send_data;
      miso16[0] = send_data16;
      tick();
      send_ready = 1'b0;
      for (int k = 0; k < n; k++) begin
         repeat (20) tick();
         recv_data  = tx[k];
         recv_ready = 1'b1;
         send_ready = 1'b1;
         @(negedge clk);
         miso[k+1]   = send_data;
         miso16[k+1] = send_data16;
         tick();
         recv_ready = 1'b0;
         send_ready = 1'b0;
      end
   endtask

   task automatic close_frame();
      repeat (4) tick();
      spi_ss = 1'b1;
      repeat (6) tick();
   endtask

   typedef struct {
      logic [0:3][7:0] tx;
      int              n;
      logic [0:3][7:0] rep;
      bit              is_rd;
      logic [0:2][6:0] saddr;
      logic [0:2][7:0] sdata;
      int              ns;
      logic            err;
   } vec_t;

   task automatic apply_vec(input int id, input vec_t v);
      int w0, r0;
      w0 = we_cnt;
      r0 = re_cnt;
      for (int i = 0; i < v.n; i++) tx[i] = v.tx[i];
      run_frame(v.n);
      check($sformatf("v%0d frame_active", id), frame_active, 1'b1);
      close_frame();
      check($sformatf("v%0d frame_active_end", id), frame_active, 1'b0);
      check($sformatf("v%0d frame_err", id), frame_err, v.err);
      for (int i = 0; i < v.n; i++)
         check($sformatf("v%0d reply%0d", id, i), miso[i], v.rep[i]);
      if (v.is_rd) begin
         check($sformatf("v%0d no_write", id), we_cnt - w0, 0);
         for (int i = 0; i < v.ns; i++)
            check($sformatf("v%0d re_addr%0d", id, i), re_addr_log[(r0 + i) & 63], v.saddr[i]);
      end else begin
         check($sformatf("v%0d we_count", id), we_cnt - w0, v.ns);
         check($sformatf("v%0d no_read", id), re_cnt - r0, 0);
         for (int i = 0; i < v.ns; i++) begin
            check($sformatf("v%0d we_addr%0d", id, i), we_addr_log[(w0 + i) & 63], v.saddr[i]);
            check($sformatf("v%0d we_data%0d", id, i), we_data_log[(w0 + i) & 63], v.sdata[i]);
         end
      end
   endtask

   vec_t vecs [6];

   initial begin
      int w0, r0;
      vec_t v;

      vecs[0] = '{tx: {8'h05, 8'h11, 8'h22, 8'h00}, n: 3, rep: {8'hA1, 8'hA1, 8'hA1, 8'h00},
                  is_rd: 1'b0, saddr: {7'd5, 7'd6, 7'd0}, sdata: {8'h11, 8'h22, 8'h00}, ns: 2, err: 1'b0};
      vecs[1] = '{tx: {8'h83, 8'h00, 8'h00, 8'h00}, n: 4, rep: {8'hA1, 8'hA1, 8'h3C, 8'h4D},
                  is_rd: 1'b1, saddr: {7'd3, 7'd4, 7'd5}, sdata: '0, ns: 3, err: 1'b0};
      vecs[2] = '{tx: {8'hFF, 8'h00, 8'h00, 8'h00}, n: 4, rep: {8'hA1, 8'hA1, 8'h7F, 8'h80},
                  is_rd: 1'b1, saddr: {7'd127, 7'd0, 7'd1}, sdata: '0, ns: 3, err: 1'b0};
      vecs[3] = '{tx: {8'h7F, 8'hAA, 8'hBB, 8'h00}, n: 3, rep: {8'hA1, 8'hA1, 8'hA1, 8'h00},
                  is_rd: 1'b0, saddr: {7'd127, 7'd0, 7'd0}, sdata: {8'hAA, 8'hBB, 8'h00}, ns: 2, err: 1'b0};
      vecs[4] = '{tx: {8'h10, 8'h55, 8'h00, 8'h00}, n: 2, rep: {8'hA1, 8'hA1, 8'h00, 8'h00},
                  is_rd: 1'b0, saddr: {7'd16, 7'd0, 7'd0}, sdata: {8'h55, 8'h00, 8'h00}, ns: 1, err: 1'b0};
      vecs[5] = '{tx: {8'h84, 8'hFF, 8'hFF, 8'h00}, n: 3, rep: {8'hA1, 8'hA1, 8'h4D, 8'h00},
                  is_rd: 1'b1, saddr: {7'd4, 7'd5, 7'd0}, sdata: '0, ns: 2, err: 1'b0};

      // Reset state.
      #23;
      check("rst reg_we", reg_we, 1'b0);
      check("rst reg_re", reg_re, 1'b0);
      check("rst reg_addr", reg_addr, 7'd0);
      check("rst reg_wdata", reg_wdata, 8'h00);
      check("rst frame_active", frame_active, 1'b0);
      check("rst frame_err", frame_err, 1'b0);
      check("rst send_data", send_data, 8'hA1);
      tick();
      rst_n = 1'b1;
      repeat (6) tick();

      for (int i = 0; i < 6; i++) apply_vec(i, vecs[i]);

      // Out-of-range write on the 16-register instance.
      w0 = we16_cnt;
      tx[0] = 8'h10; tx[1] = 8'h55;
      run_frame(2);
      close_frame();
      check("oor no_we16", we16_cnt - w0, 0);
      check("oor frame_err16", frame_err16, 1'b1);

      // Next frame reports the error in its first reply, then clears it.
      tx[0] = 8'h81; tx[1] = 8'h00;
      run_frame(2);
      check("status16 reply0", miso16[0], 8'hA3);
      check("status reply0", miso[0], 8'hA1);
      check("err16 cleared", frame_err16, 1'b0);
      close_frame();

      // ss rises in the middle of the first data byte.
      w0 = we_cnt;
      tx[0] = 8'h07;
      run_frame(1);
      check("abort frame_active", frame_active, 1'b1);
      repeat (10) tick();
      spi_ss = 1'b1;
      repeat (3) tick();
      check("abort idle_in_3", frame_active, 1'b0);
      repeat (6) tick();
      check("abort no_we", we_cnt - w0, 0);
      v = '{tx: {8'h09, 8'h99, 8'h00, 8'h00}, n: 2, rep: {8'hA1, 8'hA1, 8'h00, 8'h00},
            is_rd: 1'b0, saddr: {7'd9, 7'd0, 7'd0}, sdata: {8'h99, 8'h00, 8'h00}, ns: 1, err: 1'b0};
      apply_vec(10, v);

      // Reset pulsed while a read frame is in RD.
      tx[0] = 8'h83; tx[1] = 8'h00;
      run_frame(2);
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      check("midrst frame_active", frame_active, 1'b0);
      check("midrst reg_re", reg_re, 1'b0);
      check("midrst reg_we", reg_we, 1'b0);
      check("midrst reg_addr", reg_addr, 7'd0);
      check("midrst frame_err", frame_err, 1'b0);
      check("midrst send_data", send_data, 8'hA1);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      // A leftover byte of the interrupted frame must not be taken as a command.
      r0 = re_cnt;
      recv_data  = 8'h85;
      recv_ready = 1'b1;
      tick();
      recv_ready = 1'b0;
      repeat (3) tick();
      check("midrst stray_ignored", frame_active, 1'b0);
      check("midrst stray_no_re", re_cnt - r0, 0);
      spi_ss = 1'b1;
      repeat (6) tick();
      v = '{tx: {8'h84, 8'h00, 8'h00, 8'h00}, n: 4, rep: {8'hA1, 8'hA1, 8'h4D, 8'h5E},
            is_rd: 1'b1, saddr: {7'd4, 7'd5, 7'd6}, sdata: '0, ns: 3, err: 1'b0};
      apply_vec(11, v);

      check("send_data stable", stab_viol, 0);
      check("we_re exclusive", both_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
